// File: rtl/sva_mon_pkg.sv
// Shared types and limits for the implication monitor and its downstream tally logic.
package sva_mon_pkg;

    localparam int unsigned MAX_DELAY = 15;

    typedef enum logic [1:0] {
        RES_NONE,
        RES_PASS,
        RES_FAIL,
        RES_VACUOUS
    } sva_result_t;

    function automatic string result_to_str(input sva_result_t r);
        case (r)
            RES_NONE:    return "NONE";
            RES_PASS:    return "PASS";
            RES_FAIL:    return "FAIL";
            RES_VACUOUS: return "VACUOUS";
            default:     return "UNKNOWN";
        endcase
    endfunction

endpackage

// File: rtl/sva_sat_counter.sv
// Saturating event counter; a clear loads the same-edge increment so no event is dropped.
module sva_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = W'(inc_i);
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/sva_implication_monitor.sv
// Clocked implication check (ant |-> ##DELAY cons, disable iff disable_i) producing
// registered pass/fail/vacuous pulses, an in-flight count and saturating tallies.
module sva_implication_monitor
    import sva_mon_pkg::*;
#(
    parameter int unsigned DELAY = 0,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             disable_i,
    input  logic             ant_i,
    input  logic             cons_i,
    input  logic             clear_i,
    output logic             pass_o,
    output logic             fail_o,
    output logic             vacuous_o,
    output logic [CNT_W-1:0] pass_count_o,
    output logic [CNT_W-1:0] fail_count_o,
    output logic [4:0]       pending_o
);

    if (DELAY > MAX_DELAY) begin : g_bad_delay
        $fatal(1, "sva_implication_monitor: DELAY %0d exceeds MAX_DELAY %0d", DELAY, MAX_DELAY);
    end

    logic        active;
    logic        mature;
    logic [4:0]  pend_cnt_d;

    sva_result_t result_q;
    sva_result_t result_d;
    logic        vacuous_q;
    logic        vacuous_d;
    logic [4:0]  pending_q;
    logic        pass_inc;
    logic        fail_inc;

    assign active = ~disable_i;

    if (DELAY == 0) begin : g_overlap
        // Overlapping implication: the attempt matures on its own start edge.
        assign mature     = ant_i;
        assign pend_cnt_d = '0;
    end else begin : g_pipe
        logic [DELAY-1:0] pend_q;
        logic [DELAY-1:0] pend_d;

        always_comb begin
            pend_d = '0;
            if (active) begin
                pend_d = DELAY'({pend_q, ant_i});
            end
        end

        always_comb begin
            pend_cnt_d = '0;
            for (int unsigned i = 0; i < DELAY; i++) begin
                pend_cnt_d = pend_cnt_d + 5'(pend_d[i]);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                pend_q <= '0;
            end else begin
                pend_q <= pend_d;
            end
        end

        assign mature = pend_q[DELAY-1];
    end

    // Vacuous tracking stays separate: with DELAY>0 it can coincide with a maturation.
    always_comb begin
        result_d = RES_NONE;
        if (active && mature) begin
            result_d = cons_i ? RES_PASS : RES_FAIL;
        end
    end

    assign vacuous_d = active & ~ant_i;
    assign pass_inc  = (result_d == RES_PASS);
    assign fail_inc  = (result_d == RES_FAIL);

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q  <= RES_NONE;
            vacuous_q <= 1'b0;
            pending_q <= '0;
        end else begin
            result_q  <= result_d;
            vacuous_q <= vacuous_d;
            pending_q <= pend_cnt_d;
        end
    end

    assign pass_o    = (result_q == RES_PASS);
    assign fail_o    = (result_q == RES_FAIL);
    assign vacuous_o = vacuous_q;
    assign pending_o = pending_q;

    sva_sat_counter #(
        .W(CNT_W)
    ) u_pass_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear_i (clear_i),
        .inc_i   (pass_inc),
        .count_o (pass_count_o)
    );

    sva_sat_counter #(
        .W(CNT_W)
    ) u_fail_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear_i (clear_i),
        .inc_i   (fail_inc),
        .count_o (fail_count_o)
    );

endmodule

// File: tb/tb_sva_implication_monitor.sv
// Randomized plus directed bench: four monitors (DELAY 0..3) share one stimulus stream
// and are compared every cycle against a history-based model of the implication rules.
module tb_sva_implication_monitor;

    localparam int NI   = 4;
    localparam int HMAX = 4096;

    logic clk = 1'b0;
    logic rst, dis, ant, cons, clr;

    logic        pass_a [NI];
    logic        fail_a [NI];
    logic        vac_a  [NI];
    logic [4:0]  pend_a [NI];
    logic [15:0] pc_a   [NI];
    logic [15:0] fc_a   [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned CW = (g == 0 || g == 3) ? 4 : 16;
        logic [CW-1:0] pc, fc;
        logic          p, f, v;
        logic [4:0]    pn;

        sva_implication_monitor #(
            .DELAY(g),
            .CNT_W(CW)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .disable_i    (dis),
            .ant_i        (ant),
            .cons_i       (cons),
            .clear_i      (clr),
            .pass_o       (p),
            .fail_o       (f),
            .vacuous_o    (v),
            .pass_count_o (pc),
            .fail_count_o (fc),
            .pending_o    (pn)
        );

        assign pass_a[g] = p;
        assign fail_a[g] = f;
        assign vac_a[g]  = v;
        assign pend_a[g] = pn;
        assign pc_a[g]   = 16'(pc);
        assign fc_a[g]   = 16'(fc);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Per-edge history of what the monitors sampled.
    bit h_act  [HMAX];
    bit h_ant  [HMAX];
    bit h_cons [HMAX];
    int n = 0;

    int m_pc [NI];
    int m_fc [NI];

    function automatic int cw_of(input int i);
        return (i == 0 || i == 3) ? 4 : 16;
    endfunction

    // An attempt started at edge s survives to edge m only if every edge s..m was active.
    function automatic bit alive(input int s, input int m);
        for (int k = s; k <= m; k++) begin
            if (!h_act[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit matures(input int d, input int m);
        if (m < d) return 1'b0;
        return h_ant[m-d] && alive(m - d, m);
    endfunction

    function automatic int in_flight(input int d, input int m);
        int c = 0;
        for (int j = m - d + 1; j <= m; j++) begin
            if (j >= 0 && h_ant[j] && alive(j, m)) c++;
        end
        return c;
    endfunction

    task automatic step(input bit r, input bit d, input bit a, input bit c, input bit cl);
        rst = r; dis = d; ant = a; cons = c; clr = cl;
        @(posedge clk);
        #1;
        h_act[n]  = !r && !d;
        h_ant[n]  = a;
        h_cons[n] = c;
        for (int i = 0; i < NI; i++) begin
            bit mt, ep, ef, ev;
            int maxc, ip, iff_;
            mt   = matures(i, n);
            ep   = mt && c;
            ef   = mt && !c;
            ev   = h_act[n] && !a;
            maxc = (1 << cw_of(i)) - 1;
            ip   = ep ? 1 : 0;
            iff_ = ef ? 1 : 0;
            if (r) begin
                m_pc[i] = 0;
                m_fc[i] = 0;
            end else if (cl) begin
                m_pc[i] = ip;
                m_fc[i] = iff_;
            end else begin
                if (ip == 1 && m_pc[i] < maxc) m_pc[i]++;
                if (iff_ == 1 && m_fc[i] < maxc) m_fc[i]++;
            end
            check($sformatf("pass[%0d]@%0d", i, n), int'(pass_a[i]), int'(ep));
            check($sformatf("fail[%0d]@%0d", i, n), int'(fail_a[i]), int'(ef));
            check($sformatf("vac[%0d]@%0d", i, n), int'(vac_a[i]), int'(ev));
            check($sformatf("pend[%0d]@%0d", i, n), int'(pend_a[i]), in_flight(i, n));
            check($sformatf("pcnt[%0d]@%0d", i, n), int'(pc_a[i]), m_pc[i]);
            check($sformatf("fcnt[%0d]@%0d", i, n), int'(fc_a[i]), m_fc[i]);
        end
        n++;
    endtask

    initial begin
        rst = 1'b1; dis = 1'b0; ant = 1'b0; cons = 1'b0; clr = 1'b0;
        for (int i = 0; i < NI; i++) begin
            m_pc[i] = 0;
            m_fc[i] = 0;
        end

        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 1, 1);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_pass[%0d]", i), int'(pass_a[i]), 0);
            check($sformatf("rst_pend[%0d]", i), int'(pend_a[i]), 0);
            check($sformatf("rst_pcnt[%0d]", i), int'(pc_a[i]), 0);
        end

        // Overlapping implication: vacuous, pass, fail, vacuous.
        step(0, 0, 0, 0, 0);
        check("tp1_vac", int'(vac_a[0]), 1);
        step(0, 0, 1, 1, 0);
        check("tp1_pass", int'(pass_a[0]), 1);
        step(0, 0, 1, 0, 0);
        check("tp1_fail", int'(fail_a[0]), 1);
        step(0, 0, 0, 1, 0);
        check("tp1_vac2", int'(vac_a[0]), 1);
        check("tp1_pcnt", int'(pc_a[0]), 1);
        check("tp1_fcnt", int'(fc_a[0]), 1);

        // DELAY=2: two back-to-back attempts, pass then fail.
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        check("tp2_pend", int'(pend_a[2]), 2);
        step(0, 0, 0, 1, 0);
        check("tp2_pass", int'(pass_a[2]), 1);
        step(0, 0, 0, 0, 0);
        check("tp2_fail", int'(fail_a[2]), 1);
        check("tp2_pcnt", int'(pc_a[2]), 1);
        check("tp2_fcnt", int'(fc_a[2]), 1);

        // DELAY=3: disable mid-obligation cancels it silently.
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        check("tp3_pend", int'(pend_a[3]), 0);
        check("tp3_vac", int'(vac_a[3]), 0);
        step(0, 0, 0, 0, 0);
        check("tp3_nofail", int'(fail_a[3]), 0);
        check("tp3_fcnt", int'(fc_a[3]), 0);

        // Saturation of a 4-bit counter.
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++) step(0, 0, 1, 1, 0);
        check("sat_pcnt0", int'(pc_a[0]), 15);
        check("sat_pcnt3", int'(pc_a[3]), 15);
        check("sat_pulse", int'(pass_a[0]), 1);

        // Clear coinciding with a fail keeps that fail.
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 7; k++) step(0, 0, 1, 0, 0);
        check("clr_pre", int'(fc_a[0]), 7);
        step(0, 0, 1, 0, 1);
        check("clr_fcnt", int'(fc_a[0]), 1);
        check("clr_fail", int'(fail_a[0]), 1);
        check("clr_pcnt", int'(pc_a[0]), 0);

        // Reset with an obligation in flight leaves nothing behind.
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0);
        check("rst_mid_pre", int'(pend_a[2]), 1);
        step(1, 0, 0, 1, 0);
        check("rst_mid_pend", int'(pend_a[2]), 0);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 0);
        check("rst_mid_pcnt", int'(pc_a[2]), 0);

        // Random traffic.
        for (int k = 0; k < 2000; k++) begin
            step(($urandom_range(63) == 0),
                 ($urandom_range(15) == 0),
                 ($urandom_range(2) != 0),
                 ($urandom_range(1) == 1),
                 ($urandom_range(31) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
